// File: rtl/prog_delay_pkg.sv
// rtl/prog_delay_pkg.sv - shared FSM state type and delay-width helper for prog_delay_line
package prog_delay_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of a field able to hold 0..max_delay inclusive.
    function automatic int dw(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

endpackage

// File: rtl/dly_ram.sv
// rtl/dly_ram.sv - sample storage: one write port, one asynchronous read port, no reset
//
// Ports:
//   clk   - write clock (rising edge)
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational)
module dly_ram #(
    parameter int P_NUM_BITS = 8,
    parameter int P_DEPTH    = 16,
    parameter int P_AW       = $clog2(P_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [P_AW-1:0]       waddr,
    input  logic [P_NUM_BITS-1:0] wdata,
    input  logic [P_AW-1:0]       raddr,
    output logic [P_NUM_BITS-1:0] rdata
);

    logic [P_NUM_BITS-1:0] mem [P_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_delay_line.sv
// rtl/prog_delay_line.sv - programmable sample delay line over a circular buffer
//
// Optional feature macro: PROG_DELAY_ZERO_EN (allows a zero delay that passes
// din straight to dout combinationally). Default build clamps a zero request to 1.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   en         - sample strobe, din accepted on every edge with en=1
//   din        - input sample
//   delay_sel  - requested delay, loaded on delay_ld
//   delay_ld   - pulse: load clamped delay_sel and restart the fill
//   flush      - pulse: restart the fill, keep current delay
//   dout       - delayed sample, zero while dout_valid=0
//   dout_valid - dout carries a sample delayed by the full current delay
//   cur_delay  - delay currently in effect
module prog_delay_line
    import prog_delay_pkg::*;
#(
    parameter int P_NUM_BITS      = 8,
    parameter int P_MAX_DELAY     = 16,
    parameter int P_DEFAULT_DELAY = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [P_NUM_BITS-1:0]        din,
    input  logic [dw(P_MAX_DELAY)-1:0]   delay_sel,
    input  logic                         delay_ld,
    input  logic                         flush,
    output logic [P_NUM_BITS-1:0]        dout,
    output logic                         dout_valid,
    output logic [dw(P_MAX_DELAY)-1:0]   cur_delay
);

    localparam int DW = dw(P_MAX_DELAY);
    localparam int AW = $clog2(P_MAX_DELAY);

    localparam logic [DW-1:0] MAX_D     = DW'(P_MAX_DELAY);
    localparam logic [DW-1:0] DEFAULT_D = DW'(P_DEFAULT_DELAY);

    state_t                state_q, state_d;
    logic [DW-1:0]         fill_q, fill_d;
    logic [DW-1:0]         delay_q, delay_d;
    logic [P_NUM_BITS-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_idx;
    logic [P_NUM_BITS-1:0] rd_data;
    logic [P_NUM_BITS-1:0] sample;
    logic [DW-1:0]         delay_m1;
    logic [DW:0]           rd_sum;

    function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] sel);
        if (sel == '0) begin
`ifdef PROG_DELAY_ZERO_EN
            return '0;
`else
            return DW'(1);
`endif
        end else if (sel > MAX_D) begin
            return MAX_D;
        end
        return sel;
    endfunction

    // The sample accepted this edge is written at wr_ptr; the one D-1 accepted
    // samples older lives D-1 slots behind it (mod depth). D=1 means the
    // incoming sample itself, taken from din since it is not in storage yet.
    always_comb begin
        delay_m1 = (delay_q == '0) ? '0 : delay_q - DW'(1);
        rd_sum   = (DW+1)'(wr_ptr_q) + (DW+1)'(P_MAX_DELAY) - (DW+1)'(delay_m1);
        if (rd_sum >= (DW+1)'(P_MAX_DELAY)) begin
            rd_idx = AW'(rd_sum - (DW+1)'(P_MAX_DELAY));
        end else begin
            rd_idx = AW'(rd_sum);
        end
        sample = (delay_m1 == '0) ? din : rd_data;
    end

    dly_ram #(
        .P_NUM_BITS (P_NUM_BITS),
        .P_DEPTH    (P_MAX_DELAY),
        .P_AW       (AW)
    ) u_ram (
        .clk   (clk),
        .we    (en & rst_n),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FILL;
            fill_q   <= '0;
            delay_q  <= DEFAULT_D;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            wr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            delay_q <= delay_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            if (en) begin
                wr_ptr_q <= (wr_ptr_q == AW'(P_MAX_DELAY - 1)) ? '0 : wr_ptr_q + AW'(1);
            end
        end
    end

    // A restart edge always drops valid; a sample arriving on it is the first
    // of the new fill, so the counter restarts at 1 rather than 0.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        delay_d = delay_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        if (delay_ld || flush) begin
            if (delay_ld) begin
                delay_d = clamp_delay(delay_sel);
            end
            state_d = FILL;
            fill_d  = en ? DW'(1) : '0;
            dout_d  = '0;
            valid_d = 1'b0;
        end else if (en) begin
            if (state_q == FILL) begin
                if (fill_q + DW'(1) >= delay_q) begin
                    state_d = RUN;
                    fill_d  = delay_q;
                    dout_d  = sample;
                    valid_d = 1'b1;
                end else begin
                    fill_d = fill_q + DW'(1);
                end
            end else begin
                dout_d = sample;
            end
        end
    end

`ifdef PROG_DELAY_ZERO_EN
    assign dout       = (delay_q == '0) ? (en ? din : '0) : dout_q;
    assign dout_valid = (delay_q == '0) ? en : valid_q;
`else
    assign dout       = dout_q;
    assign dout_valid = valid_q;
`endif
    assign cur_delay  = delay_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// tb/tb_prog_delay_line.sv - directed vector bench for prog_delay_line
module tb_prog_delay_line;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] din;
    logic [4:0] delay_sel;
    logic       delay_ld;
    logic       flush;
    logic [7:0] dout;
    logic       dout_valid;
    logic [4:0] cur_delay;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] din;
        logic [4:0] sel;
        logic       ld;
        logic       fl;
        logic [7:0] exp_dout;
        logic       exp_valid;
        logic [4:0] exp_cur;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    prog_delay_line #(
        .P_NUM_BITS      (8),
        .P_MAX_DELAY     (16),
        .P_DEFAULT_DELAY (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .din        (din),
        .delay_sel  (delay_sel),
        .delay_ld   (delay_ld),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .cur_delay  (cur_delay)
    );

    task automatic add(input logic r, input logic e, input logic [7:0] d, input logic [4:0] s,
                       input logic l, input logic f, input logic [7:0] xd, input logic xv,
                       input logic [4:0] xc);
        vec_t v;
        v = '{r, e, d, s, l, f, xd, xv, xc};
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] d, input logic [4:0] s,
                        input logic l, input logic f);
        rst_n = r; en = e; din = d; delay_sel = s; delay_ld = l; flush = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] xd, input logic xv,
                         input logic [4:0] xc);
        checks++;
        if (dout !== xd || dout_valid !== xv || cur_delay !== xc) begin
            errors++;
            $display("FAIL %s: got dout=%02h valid=%0b cur=%0d, want dout=%02h valid=%0b cur=%0d",
                     name, dout, dout_valid, cur_delay, xd, xv, xc);
        end
    endtask

    initial begin
        //   rst en din    sel ld fl   dout  v  cur
        add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 4);  // reset
        add(0, 1, 8'h99, 9, 1, 1, 8'h00, 0, 4);  // reset beats en/ld/flush
        add(1, 1, 8'h01, 0, 0, 0, 8'h00, 0, 4);  // D=4 fill
        add(1, 1, 8'h02, 0, 0, 0, 8'h00, 0, 4);
        add(1, 1, 8'h03, 0, 0, 0, 8'h00, 0, 4);
        add(1, 1, 8'h04, 0, 0, 0, 8'h01, 1, 4);  // valid rises on 4th
        add(1, 1, 8'h05, 0, 0, 0, 8'h02, 1, 4);
        add(1, 1, 8'h06, 0, 0, 0, 8'h03, 1, 4);
        add(1, 0, 8'hAA, 0, 0, 0, 8'h03, 1, 4);  // hold without en
        add(1, 1, 8'h07, 0, 0, 0, 8'h04, 1, 4);
        add(1, 1, 8'h50, 2, 1, 0, 8'h00, 0, 2);  // ld D=2 with sample
        add(1, 1, 8'h51, 0, 0, 0, 8'h50, 1, 2);
        add(1, 1, 8'h52, 0, 0, 0, 8'h51, 1, 2);
        add(1, 0, 8'h00, 9, 0, 1, 8'h00, 0, 2);  // flush keeps delay
        add(1, 1, 8'h60, 0, 0, 0, 8'h00, 0, 2);
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 2);
        add(1, 1, 8'h61, 0, 0, 0, 8'h60, 1, 2);
        add(1, 0, 8'h00, 3, 1, 0, 8'h00, 0, 3);  // D=3, en toggling
        add(1, 1, 8'h10, 0, 0, 0, 8'h00, 0, 3);
        add(1, 0, 8'h77, 0, 0, 0, 8'h00, 0, 3);
        add(1, 1, 8'h11, 0, 0, 0, 8'h00, 0, 3);
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 3);
        add(1, 1, 8'h12, 0, 0, 0, 8'h10, 1, 3);
        add(1, 0, 8'h00, 0, 0, 0, 8'h10, 1, 3);
        add(1, 1, 8'h13, 0, 0, 0, 8'h11, 1, 3);
        add(1, 0, 8'h00, 31, 1, 0, 8'h00, 0, 16); // clamp high
        add(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1);   // clamp zero to 1
        add(1, 1, 8'h21, 0, 0, 0, 8'h21, 1, 1);
        add(1, 1, 8'h22, 0, 0, 0, 8'h22, 1, 1);
        add(1, 0, 8'h00, 5, 1, 1, 8'h00, 0, 5);   // ld+flush acts as ld
        add(1, 1, 8'h31, 0, 0, 0, 8'h00, 0, 5);
        add(1, 1, 8'h32, 0, 0, 0, 8'h00, 0, 5);
        add(0, 1, 8'h33, 0, 0, 0, 8'h00, 0, 4);   // reset mid-fill
        add(1, 1, 8'h01, 0, 0, 0, 8'h00, 0, 4);

        rst_n = 0; en = 0; din = 0; delay_sel = 0; delay_ld = 0; flush = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].en, vecs[i].din, vecs[i].sel, vecs[i].ld, vecs[i].fl);
            check($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_valid, vecs[i].exp_cur);
        end

        // Maximum delay across buffer wrap: load D=16 together with sample 0x80.
        step(1, 1, 8'h80, 16, 1, 0);
        check("max_ld", 8'h00, 1'b0, 5'd16);
        for (int k = 1; k <= 19; k++) begin
            step(1, 1, 8'(8'h80 + k), 0, 0, 0);
            if (k < 15) check($sformatf("max_fill%0d", k), 8'h00, 1'b0, 5'd16);
            else        check($sformatf("max_run%0d", k), 8'(8'h80 + k - 15), 1'b1, 5'd16);
        end

        // Flush in RUN with a coincident sample, then refill to D=16 again.
        step(1, 1, 8'hC0, 0, 0, 1);
        check("flush_en", 8'h00, 1'b0, 5'd16);
        for (int k = 1; k <= 16; k++) begin
            step(1, 1, 8'(8'hC0 + k), 0, 0, 0);
            if (k < 15) check($sformatf("refill%0d", k), 8'h00, 1'b0, 5'd16);
            else        check($sformatf("rerun%0d", k), 8'(8'hC0 + k - 15), 1'b1, 5'd16);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_delay_line.md
PROG_DELAY_LINE -- requirements
Module: prog_delay_line

Interface
REQ-001 P_NUM_BITS, 8, sample width in bits.
REQ-002 P_MAX_DELAY, 16, maximum delay in accepted samples, >=2.
REQ-003 P_DEFAULT_DELAY, 4, delay after reset, 1..P_MAX_DELAY.
REQ-004 clk  in  1  clock; every flop in the block is on its rising edge.
REQ-005 rst_n  in  1  reset: synchronous, active-low.
REQ-006 en  in  1  sample strobe; din is accepted on every clk edge with en=1.
REQ-007 din  in  P_NUM_BITS  input sample.
REQ-008 delay_sel  in  DW  requested delay, DW = clog2(P_MAX_DELAY+1).
REQ-009 delay_ld  in  1  single-cycle pulse that loads delay_sel and restarts the fill.
REQ-010 flush  in  1  single-cycle pulse that restarts the fill and keeps the current delay.
REQ-011 dout  out  P_NUM_BITS  delayed sample, registered.
REQ-012 dout_valid  out  1  high when dout holds a sample delayed by the full current delay.
REQ-013 cur_delay  out  DW  delay currently in effect.

Function
REQ-014 With delay D, after the edge that accepts sample x[n], dout SHALL equal x[n-D+1], counted in accepted samples. D=1 behaves as a single register.
REQ-015 dout and dout_valid SHALL change only on edges where en=1, delay_ld=1 or flush=1.
REQ-016 Two-state FSM:
  - FILL: fill counter below D.
  - RUN: fill counter reached D.
  - FILL->RUN on the edge that accepts the D-th sample since the restart.
  - RUN->FILL on delay_ld or flush.
REQ-017 dout_valid SHALL be 1 only in RUN; dout SHALL be forced to 0 whenever dout_valid=0.
REQ-018 delay_ld SHALL set cur_delay to the clamped delay_sel on the same edge:
  - 0 becomes 1;
  - values above P_MAX_DELAY become P_MAX_DELAY.
  The same edge clears the fill counter and dout_valid.
REQ-019 flush SHALL clear the fill counter and dout_valid and SHALL leave cur_delay unchanged.
REQ-020 If en coincides with delay_ld or flush, the accepted sample SHALL count as the first sample of the new fill.
REQ-021 If delay_ld and flush are high together, the edge SHALL behave as delay_ld alone.
REQ-022 Samples accepted before a restart SHALL never appear on dout with dout_valid=1 after it.
REQ-023 Storage SHALL be a circular buffer of P_MAX_DELAY entries with one write pointer wrapping modulo P_MAX_DELAY; the read index is derived from the write pointer and cur_delay.
REQ-024 The fill counter SHALL saturate at D and SHALL not wrap.

Reset
REQ-025 While rst_n=0 at an edge:
  - dout=0, dout_valid=0;
  - cur_delay=P_DEFAULT_DELAY;
  - state=FILL, fill counter=0, write pointer=0.
REQ-026 Storage contents SHALL not be reset; REQ-017 gating hides stale data.
REQ-027 Reset SHALL take priority over en, delay_ld and flush, including during an active fill.

Configuration
REQ-028 Macro PROG_DELAY_ZERO_EN, defined:
  - delay_sel=0 loads D=0;
  - with D=0, dout=din and dout_valid=en combinationally;
  - cur_delay reads 0.
REQ-029 PROG_DELAY_ZERO_EN undefined: 0 is clamped to 1 per REQ-018 and there is no combinational path from din to dout.

Structure
REQ-030 Shared package prog_delay_pkg SHALL hold the FSM state typedef (FILL, RUN) and the DW width function.
REQ-031 Storage SHALL be a sub-module dly_ram:
  - simple dual-port, one write port and one asynchronous read port;
  - P_NUM_BITS wide, P_MAX_DELAY deep, no reset.

Verification
REQ-032 Reset, D=4, en=1 continuous, din=1,2,3,...:
  - dout_valid first rises on the edge accepting din=4;
  - dout=1 on that edge, then 2,3,... every cycle.
REQ-033 D=3, en toggling 1,0,1,0:
  - dout advances only on en edges;
  - dout_valid rises after the 3rd accepted sample.
REQ-034 In RUN with D=4, delay_ld with delay_sel=2 and en=1, din=0x50:
  - dout_valid=0 on that edge;
  - on the next accepted sample 0x51, dout_valid=1 and dout=0x50.
REQ-035 delay_sel=31 with P_MAX_DELAY=16 gives cur_delay=16.
REQ-036 delay_sel=0 without the macro gives cur_delay=1; with PROG_DELAY_ZERO_EN, dout tracks din in the same cycle.
REQ-037 flush and delay_ld asserted together with delay_sel=5 gives cur_delay=5 and FILL.
REQ-038 rst_n dropped mid-FILL gives dout=0, dout_valid=0 and cur_delay=4 on the next edge.
